// File: rtl/data_mem_pkg.sv
// Shared encodings for the byte-enabled data memory: access sizes and controller states.
package data_mem_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [1:0] SZ_RSVD = 2'b11;

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

endpackage

// File: rtl/load_align.sv
// Extracts the addressed byte/half/word from a memory word, right-aligns it and sign/zero-extends it.
module load_align
   import data_mem_pkg::*;
#(
   parameter  int WIDTH = 32,
   localparam int OFF   = $clog2(WIDTH / 8)
) (
   input  logic [WIDTH-1:0] word,
   input  logic [1:0]       size,
   input  logic [OFF-1:0]   off,
   input  logic             uns,
   output logic [WIDTH-1:0] data
);

   logic [WIDTH-1:0] shifted;

   assign shifted = word >> {off, 3'b000};

   always_comb begin
      data = shifted;
      case (size)
         SZ_BYTE: data = {{(WIDTH - 8){~uns & shifted[7]}}, shifted[7:0]};
         SZ_HALF: data = {{(WIDTH - 16){~uns & shifted[15]}}, shifted[15:0]};
         default: data = shifted;
      endcase
   end

endmodule

// File: rtl/data_memory_be.sv
// Byte-addressed data memory with lane enables, a post-reset clearing sweep and a
// fixed one-cycle request/response pipeline.
module data_memory_be
   import data_mem_pkg::*;
#(
   parameter int WIDTH      = 32,
   parameter int DEPTH      = 256,
   parameter int ADDR       = 32,
   parameter int TEST_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [1:0]            req_size,
   input  logic                  req_unsigned,
   input  logic [ADDR-1:0]       req_addr,
   input  logic [WIDTH-1:0]      req_wdata,
   output logic                  rsp_valid,
   output logic [WIDTH-1:0]      rsp_rdata,
   output logic                  rsp_err,
   output logic                  init_done,
   output logic [TEST_WIDTH-1:0] test_value
);

   localparam int NB   = WIDTH / 8;
   localparam int OFF  = $clog2(NB);
   localparam int IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int WIW  = ADDR - OFF;
   localparam logic [WIW-1:0] DEPTH_W = WIW'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];

   state_t           state_reg, state_next;
   logic [IDXW-1:0]  sweep_reg, sweep_next;

   logic [WIW-1:0]   word_idx;
   logic [OFF-1:0]   byte_off;
   logic [NB-1:0]    lane_be;
   logic             req_err;
   logic             accept;

   logic             wr_en;
   logic [IDXW-1:0]  wr_idx;
   logic [NB-1:0]    wr_be;
   logic [WIDTH-1:0] wr_data;

   logic [WIDTH-1:0] rd_word_reg;
   logic [WIDTH-1:0] aligned;
   logic             rsp_valid_reg, rsp_err_reg, load_ok_reg, uns_reg;
   logic [1:0]       size_reg;
   logic [OFF-1:0]   off_reg;

   assign word_idx = req_addr[ADDR-1:OFF];
   assign byte_off = req_addr[OFF-1:0];
   assign accept   = req_valid && (state_reg == ST_RUN);

   assign req_err = (req_size == SZ_RSVD)
                 || (req_size == SZ_HALF && req_addr[0])
                 || (req_size == SZ_WORD && byte_off != '0)
                 || (word_idx >= DEPTH_W);

   for (genvar gi = 0; gi < NB; gi++) begin : g_lane
      assign lane_be[gi] = (req_size == SZ_WORD)
                        || (req_size == SZ_BYTE && byte_off == OFF'(gi))
                        || (req_size == SZ_HALF && byte_off[OFF-1:1] == (OFF - 1)'(gi / 2));
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg <= ST_INIT;
         sweep_reg <= '0;
      end else begin
         state_reg <= state_next;
         sweep_reg <= sweep_next;
      end
   end

   // The sweep and accepted stores share the single write port; they never overlap in time.
   always_comb begin
      state_next = state_reg;
      sweep_next = sweep_reg;
      req_ready  = 1'b0;
      init_done  = 1'b0;
      wr_en      = 1'b0;
      wr_idx     = sweep_reg;
      wr_be      = '1;
      wr_data    = '0;
      case (state_reg)
         ST_INIT: begin
            wr_en      = 1'b1;
            sweep_next = sweep_reg + 1'b1;
            if (sweep_reg == IDXW'(DEPTH - 1)) begin
               state_next = ST_RUN;
               sweep_next = '0;
            end
         end
         ST_RUN: begin
            req_ready = 1'b1;
            init_done = 1'b1;
            if (req_valid && req_we && !req_err) begin
               wr_en   = 1'b1;
               wr_idx  = word_idx[IDXW-1:0];
               wr_be   = lane_be;
               wr_data = req_wdata << {byte_off, 3'b000};
            end
         end
         default: state_next = ST_INIT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int b = 0; b < NB; b++) begin
            if (wr_be[b]) mem[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (accept && !req_we && !req_err) rd_word_reg <= mem[word_idx[IDXW-1:0]];
   end

   // Response metadata only moves on accept, so rdata/err hold between pulses.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rsp_valid_reg <= 1'b0;
         rsp_err_reg   <= 1'b0;
         load_ok_reg   <= 1'b0;
         size_reg      <= SZ_BYTE;
         off_reg       <= '0;
         uns_reg       <= 1'b0;
      end else begin
         rsp_valid_reg <= accept;
         if (accept) begin
            rsp_err_reg <= req_err;
            load_ok_reg <= !req_we && !req_err;
            size_reg    <= req_size;
            off_reg     <= byte_off;
            uns_reg     <= req_unsigned;
         end
      end
   end

   load_align #(.WIDTH(WIDTH)) u_align (
      .word (rd_word_reg),
      .size (size_reg),
      .off  (off_reg),
      .uns  (uns_reg),
      .data (aligned)
   );

   assign rsp_valid  = rsp_valid_reg;
   assign rsp_err    = rsp_err_reg;
   assign rsp_rdata  = load_ok_reg ? aligned : '0;
   assign test_value = mem[0][TEST_WIDTH-1:0];

endmodule

// File: tb/tb_data_memory_be.sv
// Directed bench for data_memory_be: sweep timing, byte lanes, extension, errors, throughput and reset.
module tb_data_memory_be;

   localparam int DEPTH = 256;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [1:0]  req_size = 2'b00;
   logic        req_unsigned = 1'b0;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        init_done;
   logic [15:0] test_value;

   int tests_run = 0;
   int tests_failed = 0;

   data_memory_be #(.WIDTH(32), .DEPTH(DEPTH), .ADDR(32), .TEST_WIDTH(16)) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_we       (req_we),
      .req_size     (req_size),
      .req_unsigned (req_unsigned),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .rsp_valid    (rsp_valid),
      .rsp_rdata    (rsp_rdata),
      .rsp_err      (rsp_err),
      .init_done    (init_done),
      .test_value   (test_value)
   );

   always #5 clk = ~clk;

   // Single request: present on a falling edge, accepted on the next rising edge, response sampled one falling edge later.
   task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic v, output logic [31:0] d, output logic e);
      @(negedge clk);
      req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
      req_addr = a; req_wdata = wd;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      v = rsp_valid; d = rsp_rdata; e = rsp_err;
      $display("[TB] req we=%0b sz=%0d uns=%0b addr=0x%08h wdata=0x%08h -> valid=%0b rdata=0x%08h err=%0b",
               we, sz, uns, a, wd, v, d, e);
   endtask

   task automatic test_reset;
      logic v, e;
      logic [31:0] d;
      int seen;
      int ready_early;
      seen = -1;
      ready_early = 0;
      rst = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      tests_run++;
      if (req_ready !== 1'b0 || init_done !== 1'b0 || rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0) begin
         tests_failed++;
         $display("FAIL reset_outputs: ready=%b done=%b valid=%b err=%b rdata=%h, required all zero",
                  req_ready, init_done, rsp_valid, rsp_err, rsp_rdata);
      end
      rst = 1'b1;
      for (int n = 1; n <= DEPTH + 10; n++) begin
         @(posedge clk);
         #1;
         if (init_done === 1'b1) begin
            seen = n;
            break;
         end
         if (req_ready !== 1'b0) ready_early++;
      end
      $display("[TB] sweep: init_done after %0d cycles", seen);
      tests_run++;
      if (seen != DEPTH) begin
         tests_failed++;
         $display("FAIL sweep_length: init_done after %0d cycles, required %0d", seen, DEPTH);
      end
      tests_run++;
      if (ready_early != 0) begin
         tests_failed++;
         $display("FAIL ready_during_sweep: req_ready high on %0d sweep cycles, required 0", ready_early);
      end
      tests_run++;
      if (test_value !== 16'h0) begin
         tests_failed++;
         $display("FAIL sweep_test_value: got 0x%04h, required 0x0000", test_value);
      end
      issue(1'b0, 2'b10, 1'b0, 32'h0, 32'h0, v, d, e);
      tests_run++;
      if (v !== 1'b1 || d !== 32'h0 || e !== 1'b0) begin
         tests_failed++;
         $display("FAIL sweep_word0: valid=%b rdata=0x%08h err=%b, required 1/0x00000000/0", v, d, e);
      end
   endtask

   task automatic test_byte_lanes;
      logic v, e;
      logic [31:0] d;
      issue(1'b1, 2'b10, 1'b0, 32'h0, 32'h11223344, v, d, e);
      tests_run++;
      if (v !== 1'b1 || d !== 32'h0 || e !== 1'b0) begin
         tests_failed++;
         $display("FAIL sw_response: valid=%b rdata=0x%08h err=%b, required 1/0x00000000/0", v, d, e);
      end
      issue(1'b1, 2'b00, 1'b0, 32'h1, 32'h000000AA, v, d, e);
      issue(1'b0, 2'b10, 1'b0, 32'h0, 32'h0, v, d, e);
      tests_run++;
      if (v !== 1'b1 || d !== 32'h1122AA44 || e !== 1'b0) begin
         tests_failed++;
         $display("FAIL byte_lane: valid=%b rdata=0x%08h err=%b, required 1/0x1122aa44/0", v, d, e);
      end
      tests_run++;
      if (test_value !== 16'hAA44) begin
         tests_failed++;
         $display("FAIL test_value_word0: got 0x%04h, required 0xaa44", test_value);
      end
   endtask

   task automatic test_extension;
      logic v, e;
      logic [31:0] d;
      logic [1:0]  sz  [4] = '{2'b01, 2'b01, 2'b00, 2'b00};
      logic        uns [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
      logic [31:0] adr [4] = '{32'h4, 32'h4, 32'h4, 32'h5};
      logic [31:0] exp [4] = '{32'hFFFF80F0, 32'h000080F0, 32'hFFFFFFF0, 32'h00000080};
      issue(1'b1, 2'b10, 1'b0, 32'h4, 32'h000080F0, v, d, e);
      for (int i = 0; i < 4; i++) begin
         issue(1'b0, sz[i], uns[i], adr[i], 32'h0, v, d, e);
         tests_run++;
         if (v !== 1'b1 || d !== exp[i] || e !== 1'b0) begin
            tests_failed++;
            $display("FAIL extension_%0d: valid=%b rdata=0x%08h err=%b, required 1/0x%08h/0", i, v, d, e, exp[i]);
         end
      end
   endtask

   task automatic test_errors;
      logic v, e;
      logic [31:0] d;
      logic        we  [3] = '{1'b0, 1'b1, 1'b0};
      logic [1:0]  sz  [3] = '{2'b10, 2'b01, 2'b10};
      logic [31:0] adr [3] = '{32'h2, 32'h3, DEPTH * 4};
      for (int i = 0; i < 3; i++) begin
         issue(we[i], sz[i], 1'b0, adr[i], 32'hFFFFBEEF, v, d, e);
         tests_run++;
         if (v !== 1'b1 || d !== 32'h0 || e !== 1'b1) begin
            tests_failed++;
            $display("FAIL error_%0d: valid=%b rdata=0x%08h err=%b, required 1/0x00000000/1", i, v, d, e);
         end
      end
      issue(1'b1, 2'b11, 1'b0, 32'h0, 32'hFFFFFFFF, v, d, e);
      tests_run++;
      if (e !== 1'b1) begin
         tests_failed++;
         $display("FAIL error_reserved_size: err=%b, required 1", e);
      end
      issue(1'b0, 2'b10, 1'b0, 32'h0, 32'h0, v, d, e);
      tests_run++;
      if (d !== 32'h1122AA44 || e !== 1'b0) begin
         tests_failed++;
         $display("FAIL error_mem_word0: rdata=0x%08h err=%b, required 0x1122aa44/0", d, e);
      end
      issue(1'b0, 2'b10, 1'b0, 32'h4, 32'h0, v, d, e);
      tests_run++;
      if (d !== 32'h000080F0 || e !== 1'b0) begin
         tests_failed++;
         $display("FAIL error_mem_word1: rdata=0x%08h err=%b, required 0x000080f0/0", d, e);
      end
      @(negedge clk);
      tests_run++;
      if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h000080F0) begin
         tests_failed++;
         $display("FAIL rsp_hold: valid=%b rdata=0x%08h, required 0/0x000080f0", rsp_valid, rsp_rdata);
      end
   endtask

   task automatic test_back_to_back;
      logic        we  [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      logic [1:0]  sz  [8] = '{2'b10, 2'b10, 2'b00, 2'b10, 2'b01, 2'b01, 2'b00, 2'b01};
      logic        uns [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      logic [31:0] adr [8] = '{32'h8, 32'h8, 32'h9, 32'h8, 32'hE, 32'hE, 32'hB, 32'h9};
      logic [31:0] wd  [8] = '{32'hDEADBEEF, 32'h0, 32'h55, 32'h0, 32'h1234, 32'h0, 32'h0, 32'h0};
      logic [31:0] exp [8] = '{32'h0, 32'hDEADBEEF, 32'h0, 32'hDEAD55EF, 32'h0, 32'h00001234, 32'hFFFFFFDE, 32'h0};
      logic        xer [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      for (int i = 0; i <= 8; i++) begin
         @(negedge clk);
         if (i > 0) begin
            $display("[TB] b2b rsp %0d: valid=%0b rdata=0x%08h err=%0b", i - 1, rsp_valid, rsp_rdata, rsp_err);
            tests_run++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== exp[i-1] || rsp_err !== xer[i-1]) begin
               tests_failed++;
               $display("FAIL b2b_%0d: valid=%b rdata=0x%08h err=%b, required 1/0x%08h/%b",
                        i - 1, rsp_valid, rsp_rdata, rsp_err, exp[i-1], xer[i-1]);
            end
         end
         if (i < 8) begin
            req_valid = 1'b1; req_we = we[i]; req_size = sz[i]; req_unsigned = uns[i];
            req_addr = adr[i]; req_wdata = wd[i];
         end else begin
            req_valid = 1'b0;
         end
      end
      @(negedge clk);
      tests_run++;
      if (rsp_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL b2b_idle: valid=%b, required 0", rsp_valid);
      end
   endtask

   task automatic test_reset_mid_traffic;
      logic v, e;
      logic [31:0] d;
      int seen;
      seen = -1;
      for (int i = 0; i <= 3; i++) begin
         @(negedge clk);
         if (i > 0) begin
            tests_run++;
            if (rsp_valid !== 1'b1) begin
               tests_failed++;
               $display("FAIL mid_rsp_%0d: valid=%b, required 1", i - 1, rsp_valid);
            end
         end
         req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
         req_addr = 32'(i * 4); req_wdata = 32'h0;
         if (i == 3) begin
            rst = 1'b0;
            #1;
            $display("[TB] reset on 4th request: valid=%0b ready=%0b done=%0b", rsp_valid, req_ready, init_done);
            tests_run++;
            if (rsp_valid !== 1'b0 || req_ready !== 1'b0 || init_done !== 1'b0 || rsp_rdata !== 32'h0) begin
               tests_failed++;
               $display("FAIL mid_reset_async: valid=%b ready=%b done=%b rdata=0x%08h, required 0/0/0/0",
                        rsp_valid, req_ready, init_done, rsp_rdata);
            end
         end
      end
      @(negedge clk);
      req_valid = 1'b0;
      rst = 1'b1;
      for (int n = 1; n <= DEPTH + 10; n++) begin
         @(posedge clk);
         #1;
         if (init_done === 1'b1) begin
            seen = n;
            break;
         end
      end
      $display("[TB] resweep: init_done after %0d cycles", seen);
      tests_run++;
      if (seen != DEPTH) begin
         tests_failed++;
         $display("FAIL resweep_length: init_done after %0d cycles, required %0d", seen, DEPTH);
      end
      tests_run++;
      if (test_value !== 16'h0) begin
         tests_failed++;
         $display("FAIL resweep_test_value: got 0x%04h, required 0x0000", test_value);
      end
      issue(1'b0, 2'b10, 1'b0, 32'h8, 32'h0, v, d, e);
      tests_run++;
      if (v !== 1'b1 || d !== 32'h0 || e !== 1'b0) begin
         tests_failed++;
         $display("FAIL resweep_word2: valid=%b rdata=0x%08h err=%b, required 1/0x00000000/0", v, d, e);
      end
   endtask

   initial begin
      test_reset();
      test_byte_lanes();
      test_extension();
      test_errors();
      test_back_to_back();
      test_reset_mid_traffic();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: bench still running at %0t, required to finish earlier", $time);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/data_memory_be.md
DATA_MEMORY_BE -- requirements
Module: data_memory_be

Interface
REQ-001 SHALL take parameter WIDTH, default 32: data word width in bits, 32 or 64.
REQ-002 SHALL take parameter DEPTH, default 256: number of words.
REQ-003 SHALL take parameter ADDR, default 32: byte-address width.
REQ-004 SHALL take parameter TEST_WIDTH, default 16: width of the observation port.
REQ-005 SHALL have port clk, input, 1: single clock; all state changes on rising edge.
REQ-006 SHALL have port rst, input, 1: reset, asynchronous, active-low.
REQ-007 SHALL have port req_valid, input, 1: request present.
REQ-008 SHALL have port req_ready, output, 1: block accepts a request this cycle.
REQ-009 SHALL have port req_we, input, 1: 1 = store, 0 = load.
REQ-010 SHALL have port req_size, input, 2: 00 byte, 01 half, 10 full word (WIDTH bits), 11 reserved.
REQ-011 SHALL have port req_unsigned, input, 1: load zero-extends when 1, sign-extends when 0.
REQ-012 SHALL have port req_addr, input, ADDR: byte address.
REQ-013 SHALL have port req_wdata, input, WIDTH: store data, right-aligned.
REQ-014 SHALL have port rsp_valid, output, 1: one-cycle response pulse.
REQ-015 SHALL have port rsp_rdata, output, WIDTH: load result.
REQ-016 SHALL have port rsp_err, output, 1: request misaligned, out of range or reserved size.
REQ-017 SHALL have port init_done, output, 1: memory clear sweep complete.
REQ-018 SHALL have port test_value, output, TEST_WIDTH: word 0 bits [TEST_WIDTH-1:0], combinational.

Function
REQ-019 SHALL derive OFF = log2(WIDTH/8); word index = req_addr[ADDR-1:OFF]; byte offset = req_addr[OFF-1:0].
REQ-020 SHALL implement FSM states INIT and RUN; reset enters INIT.
REQ-021 In INIT SHALL write zero to word k on cycle k (k = 0..DEPTH-1), hold req_ready=0, then enter RUN with init_done=1; the state never leaves RUN except by reset.
REQ-022 In RUN SHALL drive req_ready=1 and accept a request on every cycle with req_valid=1, back-to-back with no bubbles.
REQ-023 An accepted request SHALL be flagged in error when: size 11; half with addr[0]!=0; full word with offset!=0; or word index >= DEPTH.
REQ-024 An accepted store without error SHALL update only the addressed bytes (byte-lane enables from size and offset) at the accept edge.
REQ-025 An accepted load without error SHALL give rsp_rdata = addressed byte/half/word, shifted to bit 0, sign- or zero-extended to WIDTH.
REQ-026 Every accepted request, load or store, SHALL produce rsp_valid=1 exactly one cycle after acceptance; otherwise rsp_valid=0.
REQ-027 rsp_rdata SHALL be 0 for stores and for errored requests; rsp_err SHALL be valid only with rsp_valid.
REQ-028 An errored store SHALL leave memory unchanged.
REQ-029 A load accepted the cycle after a store to the same word SHALL return the stored data; no forwarding path is needed.
REQ-030 rsp_rdata and rsp_err SHALL hold their last values while rsp_valid=0.

Reset
REQ-031 Asserting rst SHALL immediately force: state=INIT, sweep counter=0, req_ready=0, init_done=0, rsp_valid=0, rsp_err=0, rsp_rdata=0.
REQ-032 The memory array SHALL NOT be reset directly; it is cleared only by the INIT sweep.
REQ-033 Reset mid-sweep or mid-traffic SHALL drop in-flight responses and restart the sweep from word 0.

Structure
REQ-034 A shared package data_mem_pkg SHALL hold the size encodings (SZ_BYTE, SZ_HALF, SZ_WORD) and the FSM state constants.
REQ-035 Load extraction and extension SHALL be one combinational sub-module, load_align (WIDTH-parametrised).

Verification
REQ-036 Sweep check: release rst -> init_done rises exactly DEPTH cycles later; req_ready=0 until then; word 0 reads 0.
REQ-037 Byte lanes: SW 0x11223344 @0x0, then SB 0xAA @0x1, then LW @0x0 -> 0x1122AA44, rsp_err=0.
REQ-038 Extension: with 0x0000_80F0 @0x4: LH @0x4 signed -> 0xFFFF80F0; LHU -> 0x000080F0; LB @0x4 -> 0xFFFFFFF0; LBU @0x5 -> 0x00000080.
REQ-039 Errors: LW @0x2, SH @0x3, LW @(DEPTH*4) -> each rsp_err=1, rsp_rdata=0, memory unchanged.
REQ-040 Throughput and reset: 8 back-to-back requests -> 8 consecutive rsp_valid pulses; assert rst on the 4th -> rsp_valid=0 same cycle, sweep restarts, test_value=0 after init_done.
